// File: rtl/hqm_rcfwl_gclk_mc_pkg.sv
// Shared types and helpers for the MC clock-distribution leaf.
package hqm_rcfwl_gclk_mc_pkg;

    // Sync lock state machine encoding.
    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } lock_state_e;

    // Width needed to hold counts 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hqm_rcfwl_gclk_mc_cg.sv
// Latch-based clock gate; stands in for the library ICG cell.
module hqm_rcfwl_gclk_mc_cg (
    input  logic clk,
    input  logic rst_b,
    input  logic en,
    output logic gclk
);

    logic en_lat;

    // Enable latch is transparent while clk is low, so gclk cannot produce a runt pulse.
    always_latch begin
        if (!rst_b) begin
            en_lat <= 1'b0;
        end else if (!clk) begin
            en_lat <= en;
        end
    end

    assign gclk = clk & en_lat;

endmodule

// File: rtl/hqm_rcfwl_gclk_mc_clkdist_mch.sv
// MC clock-spine tap: per-channel gated clocks and retimed sync pulses,
// channel enables applied only on locked sync boundaries.
module hqm_rcfwl_gclk_mc_clkdist_mch
    import hqm_rcfwl_gclk_mc_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SYNC_DLY    = 2,
    parameter int unsigned SYNC_PERIOD = 16,
    parameter int unsigned LOCK_CNT    = 2
) (
    input  logic              clkspine_in,
    input  logic              pwrgood_rst_b,
    input  logic              pll_sync_in,
    input  logic [NUM_CH-1:0] ch_en_req,
    input  logic              sync_err_clr,
    output logic [NUM_CH-1:0] ch_en_ack,
    output logic [NUM_CH-1:0] mcckpredop,
    output logic [NUM_CH-1:0] mc_pll_sync_out,
    output logic              sync_locked,
    output logic              sync_err
);

    localparam int unsigned CNT_W  = cnt_width(SYNC_PERIOD);
    localparam int unsigned GCNT_W = cnt_width(LOCK_CNT);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SYNC_PERIOD - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SYNC_PERIOD);
    localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(LOCK_CNT - 1);

    logic [SYNC_DLY-1:0] sync_pipe_q, sync_pipe_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
    lock_state_e         state_q, state_d;
    logic [NUM_CH-1:0]   ack_q, ack_d;
    logic                err_q, err_d;
    logic                sync_d;
    logic                good, early, missing;
    logic                err_set;

    assign sync_pipe_d = (sync_pipe_q << 1) | SYNC_DLY'(pll_sync_in);
    assign sync_d      = sync_pipe_q[SYNC_DLY-1];

    // Interval classification against the expected sync cadence.
    always_comb begin
        good    = sync_d && (cnt_q == CNT_LAST);
        early   = sync_d && (cnt_q < CNT_LAST);
        missing = !sync_d && (cnt_q == CNT_LAST);
        cnt_d   = cnt_q;
        if (sync_d) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Lock FSM next-state, enable application and sticky error.
    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        err_set = 1'b0;
        ack_d   = ack_q;
        err_d   = err_q;
        case (state_q)
            UNLOCK: begin
                if (sync_d) begin
                    state_d = ACQ;
                    gcnt_d  = '0;
                end
            end
            ACQ: begin
                if (good) begin
                    if (gcnt_q == GCNT_LAST) begin
                        state_d = LOCKED;
                    end else begin
                        gcnt_d = gcnt_q + GCNT_W'(1);
                    end
                end else if (early) begin
                    // the early pulse itself restarts acquisition
                    state_d = ACQ;
                    gcnt_d  = '0;
                end else if (missing) begin
                    state_d = UNLOCK;
                end
            end
            LOCKED: begin
                if (early || missing) begin
                    state_d = UNLOCK;
                    err_set = 1'b1;
                end
            end
            default: begin
                state_d = UNLOCK;
                gcnt_d  = '0;
            end
        endcase
        if (sync_d && (state_q == LOCKED) && !early) begin
            ack_d = ch_en_req;
        end
        if (err_set) begin
            err_d = 1'b1;
        end else if (sync_err_clr) begin
            err_d = 1'b0;
        end
    end

    // State registers on the spine clock.
    always_ff @(posedge clkspine_in or negedge pwrgood_rst_b) begin
        if (!pwrgood_rst_b) begin
            sync_pipe_q <= '0;
            cnt_q       <= '0;
            gcnt_q      <= '0;
            state_q     <= UNLOCK;
            ack_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            sync_pipe_q <= sync_pipe_d;
            cnt_q       <= cnt_d;
            gcnt_q      <= gcnt_d;
            state_q     <= state_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

    // One clock gate per channel.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        hqm_rcfwl_gclk_mc_cg u_cg (
            .clk   (clkspine_in),
            .rst_b (pwrgood_rst_b),
            .en    (ack_q[g]),
            .gclk  (mcckpredop[g])
        );
    end

    assign ch_en_ack       = ack_q;
    assign mc_pll_sync_out = {NUM_CH{sync_d}} & ack_q;
    assign sync_locked     = (state_q == LOCKED);
    assign sync_err        = err_q;

endmodule
